// File: rtl/mult_arbiter_pkg.sv
// Shared definitions for mult_arbiter: FSM state encoding and default operand width.
package mult_arbiter_pkg;

  // Operand width of the shared unsigned multiplier.
  localparam int WIDTH_DEFAULT = 4;

  // One transaction in flight: accept in IDLE, multiply in CALC, hold result in RESP.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mult_arbiter_umulti.sv
// umulti: combinational unsigned multiplier, full-width product with no truncation.
module umulti #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p
);

  // Zero-extend both operands so the multiply is evaluated at the product width.
  assign p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: two requesters share one umulti through a round-robin arbiter
// and an IDLE/CALC/RESP FSM. Optional per-requester completion counters are
// built when the macro MULT_ARB_STATS_EN is defined.
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEFAULT,
  parameter int RR_INIT = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  input  logic [WIDTH-1:0]   req_a0,
  input  logic [WIDTH-1:0]   req_b0,
  input  logic [WIDTH-1:0]   req_a1,
  input  logic [WIDTH-1:0]   req_b1,
  output logic [1:0]         req_ready,
  output logic [1:0]         rsp_valid,
  output logic [2*WIDTH-1:0] rsp_p,
  input  logic [1:0]         rsp_ready
`ifdef MULT_ARB_STATS_EN
  ,
  output logic [7:0]         done_cnt0,
  output logic [7:0]         done_cnt1
`endif
);

  localparam logic PRIO_RESET = (RR_INIT != 0);

  state_t               state;
  state_t               next_state;
  logic                 prio;      // requester that wins a tie
  logic                 win;       // arbitration result for this cycle
  logic                 grant;     // requester owning the in-flight transaction
  logic                 accept;    // operands taken this cycle
  logic                 done;      // response consumed this cycle
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic [2*WIDTH-1:0]   product;

  umulti #(.WIDTH(WIDTH)) u_umulti (
    .a (op_a),
    .b (op_b),
    .p (product)
  );

  // Arbitration, next-state logic and the single-cycle req_ready strobe.
  always_comb begin
    // NOTE: every output of this block is given a default first so no path leaves it unassigned and no latch is inferred.
    next_state = state;
    req_ready  = 2'b00;
    win        = prio;
    if (req_valid == 2'b01) begin
      win = 1'b0;
    end else if (req_valid == 2'b10) begin
      win = 1'b1;
    end
    unique case (state)
      IDLE: begin
        if (!rst && (req_valid != 2'b00)) begin
          req_ready[win] = 1'b1;
          next_state     = CALC;
        end
      end
      CALC:    next_state = RESP;
      RESP:    if (rsp_ready[grant]) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign accept    = (req_ready != 2'b00);
  assign done      = (state == RESP) && rsp_ready[grant];
  assign rsp_valid = (state == RESP) ? (2'b01 << grant) : 2'b00;

  // FSM state register; reset abandons any in-flight transaction.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Datapath: latch winner's operands, register the product, rotate priority on completion.
  always_ff @(posedge clk) begin
    // NOTE: operand and product registers are explicitly reset so a post-reset rsp_p is 0, not stale data.
    if (rst) begin
      prio  <= PRIO_RESET;
      grant <= 1'b0;
      op_a  <= '0;
      op_b  <= '0;
      rsp_p <= '0;
    end else begin
      if (accept) begin
        grant <= win;
        op_a  <= win ? req_a1 : req_a0;
        op_b  <= win ? req_b1 : req_b0;
      end
      if (state == CALC) begin
        rsp_p <= product;
      end
      if (done) begin
        prio <= ~prio;
      end
    end
  end

`ifdef MULT_ARB_STATS_EN
  // Completed-response counters per requester, wrapping at 8 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_cnt0 <= 8'd0;
      done_cnt1 <= 8'd0;
    end else if (done) begin
      if (grant) begin
        done_cnt1 <= done_cnt1 + 8'd1;
      end else begin
        done_cnt0 <= done_cnt0 + 8'd1;
      end
    end
  end
`endif

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter: WIDTH, default 4; operand width, SHALL equal the umulti operand width (4).
REQ-002 Parameter: RR_INIT, default 0; requester holding priority after reset (0 or 1).
REQ-003 Port: clk  input  1  rising-edge clock, single clock domain.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: req_valid  input  2  bit i = requester i has an operand pair pending.
REQ-006 Port: req_a0, req_b0  input  WIDTH each  requester 0 operands.
REQ-007 Port: req_a1, req_b1  input  WIDTH each  requester 1 operands.
REQ-008 Port: req_ready  output  2  bit i = operands of requester i accepted this cycle.
REQ-009 Port: rsp_valid  output  2  bit i = rsp_p holds the product for requester i.
REQ-010 Port: rsp_p  output  2*WIDTH  shared registered product.
REQ-011 Port: rsp_ready  input  2  bit i = requester i consumes the response.

Function
REQ-012 Block SHALL share one umulti instance between two requesters, one transaction in flight.
REQ-013 FSM states SHALL be IDLE, CALC, RESP; reset state IDLE.
REQ-014 IDLE: no req_valid -> stay; any req_valid -> grant one, set its req_ready (combinational, this cycle only), latch its operands and grant index, go CALC.
REQ-015 Arbitration SHALL be round-robin: on a tie the priority holder wins; a single valid requester wins regardless of priority.
REQ-016 Priority SHALL pass to the other requester when a transaction completes (RESP exit), regardless of which requester was served.
REQ-017 CALC: umulti output from latched operands SHALL be registered into rsp_p; go RESP.
REQ-018 RESP: rsp_valid[grant]=1, rsp_p stable; stay until rsp_ready[grant]=1, then go IDLE.
REQ-019 Latency: operands accepted at edge t SHALL yield rsp_valid at t+2.
REQ-020 rsp_ready of the non-granted requester and all req_valid SHALL be ignored outside IDLE; req_ready SHALL be 0 outside IDLE.
REQ-021 Product SHALL be unsigned, full width, no truncation (15*15 = 225).
REQ-022 Minimum issue interval SHALL be 3 cycles (IDLE, CALC, RESP with immediate rsp_ready).

Reset
REQ-023 rst in any state SHALL return the FSM to IDLE at the next edge and abandon any in-flight transaction without a response.
REQ-024 Reset values: req_ready=0 (combinational, 0 while rst asserted), rsp_valid=0, rsp_p=0, priority=RR_INIT, latched operands=0.

Configuration
REQ-025 Macro MULT_ARB_STATS_EN defined: ports done_cnt0 and done_cnt1 (output, 8 bits each) SHALL count completed responses per requester, wrap 255->0, reset to 0.
REQ-026 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding (IDLE/CALC/RESP) and the WIDTH default constant.
REQ-028 The existing umulti SHALL be the single instantiated sub-module; arbitration and FSM stay in mult_arbiter.

Verification
REQ-029 Single request: req_valid=01, a0=3, b0=2, rsp_ready=01 held -> req_ready=01 at t, rsp_valid=01 with rsp_p=6 at t+2.
REQ-030 Tie, RR_INIT=0: both valid (a0=4,b0=5; a1=7,b1=8) -> requester 0 served (20), then requester 1 (56); third tie -> requester 0.
REQ-031 Backpressure: rsp_ready=0 for 5 cycles in RESP (a1=9,b1=6) -> rsp_valid=10, rsp_p=54 held stable, no new req_ready until rsp_ready[1]=1.
REQ-032 Boundary: a=15,b=15 -> rsp_p=225; a=0,b=15 -> rsp_p=0.
REQ-033 Reset mid-op: rst asserted in CALC -> next cycle IDLE, rsp_valid=0, rsp_p=0, priority=RR_INIT, no response delivered.
REQ-034 With MULT_ARB_STATS_EN: 256 completions on requester 0 -> done_cnt0 wraps to 0, done_cnt1 unchanged.
